acc_requant_writer: RTL and testbench
=====================================

// Module: acc_requant_writer
// PURPOSE
// Downstream of the accumulator array. Captures each SIZE-wide int32 accumulator row
// on calc_done_i, adds per-column bias and requantizes to int8 using a TFLM-style
// multiplier/shift, zero point and clamp. Packs the row into a FIFO drained by the
// output-buffer writer over a valid/ready handshake; tags the last row of each tile.
// PARAMETERS
// SIZE        16  columns per row and rows per tile (matches the array dimension)
// ACC_WIDTH   32  accumulator/bias width (signed)
// OUT_WIDTH    8  requantized element width (signed)
// FIFO_DEPTH  32  row FIFO depth, power of 2, >= SIZE + 4 (one tile plus pipeline)
// PORTS
// clk              in   1                clock
// rst_n            in   1                async active-low reset
// data_in          in   ACC_WIDTH x SIZE accumulator row (unpacked [0:SIZE-1])
// calc_done_i      in   1                data_in is a valid row this cycle
// tile_calc_over_i in   1                1-cycle end-of-tile pulse from the array
// bias_i           in   ACC_WIDTH x SIZE per-column bias, static while busy
// quant_mult_i     in   32               signed Q31 multiplier, static while busy
// quant_shift_i    in   5                extra right shift 0..31, static while busy
// out_zp_i         in   OUT_WIDTH        output zero point (signed)
// act_min_i        in   OUT_WIDTH        clamp low (signed)
// act_max_i        in   OUT_WIDTH        clamp high (signed), act_min_i <= act_max_i
// out_valid_o      out  1                FIFO head valid
// out_ready_i      in   1                consumer accepts head when valid & ready
// out_data_o       out  OUT_WIDTH*SIZE   packed row, column 0 in LSBs
// out_last_o       out  1                head row is row SIZE-1 of its tile
// busy_o           out  1                FSM not IDLE or pipeline/FIFO non-empty
// overflow_o       out  1                sticky: row arrived with FIFO full
// row_cnt_err_o    out  1                sticky: tile_calc_over_i with row count != SIZE
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM IDLE, row counter 0, pipeline valids 0.
// - Pipeline per row (valid bit travels with data, no stalls):
//   S1: b = data_in[c] + bias_i[c], ACC_WIDTH wrap-around add.
//   S2: p = b * quant_mult_i, signed 64-bit product.
//   S3: r = (p + 2^(30+sh)) >>> (31+sh), sh = quant_shift_i (round half toward +inf);
//       y = r + out_zp_i; clamp y to [act_min_i, act_max_i]; truncate to OUT_WIDTH.
//   FIFO write at end of S3: row with calc_done_i in cycle N is at head, out_valid_o=1,
//   in cycle N+4 if FIFO was empty (4-cycle latency).
// - Last tag: row counter 0..SIZE-1 increments per captured row; row with count SIZE-1
//   carries last=1; counter wraps to 0.
// - FSM IDLE -> ACTIVE on first calc_done_i; ACTIVE -> WAIT_OVER after row SIZE-1;
//   WAIT_OVER -> IDLE on tile_calc_over_i. tile_calc_over_i in IDLE/ACTIVE (count != SIZE)
//   sets row_cnt_err_o, resets counter to 0, FSM -> IDLE. calc_done_i in WAIT_OVER starts
//   the next tile (counter already 0, FSM -> ACTIVE).
// - FIFO: push and pop in the same cycle allowed, even when full (pop frees slot first).
//   Push into full FIFO with no pop: row dropped, overflow_o set; pointers unchanged.
//   Pop from empty never happens (out_valid_o=0). out_data_o/out_last_o stable while
//   out_valid_o & ~out_ready_i.
// - Sticky flags clear only on reset. Reset mid-tile discards pipeline and FIFO contents.
// STRUCTURE
// - Package acc_pkg: ACC_WIDTH/OUT_WIDTH constants, requant_params_t struct (mult, shift,
//   zp, act_min, act_max), tile_state_e {IDLE, ACTIVE, WAIT_OVER}.
// - Sub-module requant_lane (one column: S1-S3 datapath), generated SIZE times; FIFO,
//   row counter and FSM inline in this module.
// TESTING
// - mult=0x4000_0000 (0.5), sh=0, zp=0, bias 0, data all 10 -> every out element 5, last on row 15.
// - data -7, mult 0.5, sh=1, zp=3 -> r=round(-1.75)=-2 -> out 1; data 2^31-1 + bias 1 wraps to -2^31.
// - Clamp: act_min=-128, act_max=0, result +50 -> 0; result -300 -> -128.
// - Hold out_ready_i=0 through 32 rows then 1 more row -> overflow_o=1, FIFO keeps first 32.
// - tile_calc_over_i after 10 rows -> row_cnt_err_o=1, next tile's row 15 still tagged last.
// - Random ready toggling over 4 back-to-back tiles: output order/data match model, no loss.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared widths, requantization parameter bundle and tile FSM encoding for the
// accumulator requantize/writeback path.
package acc_pkg;

  localparam int unsigned ACC_WIDTH   = 32;
  localparam int unsigned OUT_WIDTH   = 8;
  localparam int unsigned MULT_WIDTH  = 32;
  localparam int unsigned SHIFT_WIDTH = 5;
  localparam int unsigned PROD_WIDTH  = ACC_WIDTH + MULT_WIDTH;

  typedef struct packed {
    logic signed [MULT_WIDTH-1:0]  mult;     // Q31 multiplier
    logic        [SHIFT_WIDTH-1:0] shift;    // extra right shift
    logic signed [OUT_WIDTH-1:0]   zp;       // output zero point
    logic signed [OUT_WIDTH-1:0]   act_min;
    logic signed [OUT_WIDTH-1:0]   act_max;
  } requant_params_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    WAIT_OVER = 2'd2
  } tile_state_e;

endpackage

// File: rtl/requant_lane.sv
// One column of the requantization pipeline: bias add, Q31 multiply, then
// rounding shift, zero point and clamp. Three register stages, no stalls.
module requant_lane
  import acc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] bias,
  input  requant_params_t      params,
  output logic [OUT_WIDTH-1:0] q
);

  logic [ACC_WIDTH-1:0]          sum_q;
  logic signed [PROD_WIDTH-1:0]  prod_d, prod_q;
  logic [OUT_WIDTH-1:0]          q_d, q_q;
  logic [5:0]                    rnd_sh;
  logic signed [PROD_WIDTH-1:0]  rounded, scaled, biased, lo, hi, clamped;

  // S2 multiply: both operands sign-extended to the full product width.
  always_comb begin
    prod_d = PROD_WIDTH'($signed(sum_q)) * PROD_WIDTH'(params.mult);
  end

  // S3: round half toward +inf at bit (30+shift), add zero point, clamp, truncate.
  always_comb begin
    rnd_sh  = 6'(params.shift) + 6'd30;
    rounded = prod_q + (PROD_WIDTH'(1) << rnd_sh);
    scaled  = rounded >>> (rnd_sh + 6'd1);
    biased  = scaled + PROD_WIDTH'(params.zp);
    lo      = PROD_WIDTH'(params.act_min);
    hi      = PROD_WIDTH'(params.act_max);
    if (biased < lo) begin
      clamped = lo;
    end else if (biased > hi) begin
      clamped = hi;
    end else begin
      clamped = biased;
    end
    q_d = clamped[OUT_WIDTH-1:0];
  end

  // Stage registers; validity is tracked by the parent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      prod_q <= '0;
      q_q    <= '0;
    end else begin
      sum_q  <= acc + bias;
      prod_q <= prod_d;
      q_q    <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/acc_requant_writer.sv
// Captures accumulator rows, requantizes each column through requant_lane,
// tags the last row of each tile and queues packed rows for the output writer.
module acc_requant_writer #(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ACC_WIDTH-1:0]      data_in [0:SIZE-1],
  input  logic                      calc_done_i,
  input  logic                      tile_calc_over_i,
  input  logic [ACC_WIDTH-1:0]      bias_i [0:SIZE-1],
  input  logic [31:0]               quant_mult_i,
  input  logic [4:0]                quant_shift_i,
  input  logic [OUT_WIDTH-1:0]      out_zp_i,
  input  logic [OUT_WIDTH-1:0]      act_min_i,
  input  logic [OUT_WIDTH-1:0]      act_max_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [OUT_WIDTH*SIZE-1:0] out_data_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic                      overflow_o,
  output logic                      row_cnt_err_o
);

  import acc_pkg::*;

  localparam int unsigned CntW = $clog2(SIZE);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned RowW = OUT_WIDTH * SIZE;

  requant_params_t params;
  logic [RowW-1:0] row_q;
  logic [2:0]      valid_q, last_q;

  assign params = '{mult: quant_mult_i, shift: quant_shift_i, zp: out_zp_i,
                    act_min: act_min_i, act_max: act_max_i};

  for (genvar c = 0; c < SIZE; c++) begin : g_lane
    requant_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .acc   (data_in[c]),
      .bias  (bias_i[c]),
      .params(params),
      .q     (row_q[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // ---------------- tile FSM and row counter ----------------
  tile_state_e     state_q, state_d;
  logic [CntW-1:0] row_cnt_q, row_cnt_d, cnt_eff;
  logic            row_last, cnt_err_q, cnt_err_d;

  // End-of-tile is applied before a coincident row so that row opens the next tile.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    cnt_err_d = cnt_err_q;
    cnt_eff   = row_cnt_q;
    if (tile_calc_over_i) begin
      if (state_q != WAIT_OVER) cnt_err_d = 1'b1;
      cnt_eff = '0;
      state_d = IDLE;
    end
    row_last  = (cnt_eff == CntW'(SIZE - 1));
    row_cnt_d = cnt_eff;
    if (calc_done_i) begin
      row_cnt_d = row_last ? '0 : cnt_eff + 1'b1;
      state_d   = row_last ? WAIT_OVER : ACTIVE;
    end
  end

  // FSM, counter, sticky error and the valid/last tags riding alongside the lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      cnt_err_q <= 1'b0;
      valid_q   <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      cnt_err_q <= cnt_err_d;
      valid_q   <= {valid_q[1:0], calc_done_i};
      last_q    <= {last_q[1:0], calc_done_i & row_last};
    end
  end

  // ---------------- row FIFO ----------------
  logic [RowW:0]   mem_q [FIFO_DEPTH];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic [RowW:0]   head;
  logic            fifo_empty, fifo_full, push, pop, do_write, overflow_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push       = valid_q[2];
  assign pop        = ~fifo_empty & out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_write   = push & (~fifo_full | pop);

  // Pointers and sticky overflow; a dropped row leaves the pointers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push & fifo_full & ~pop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q[PtrW-1:0]] <= {last_q[2], row_q};
  end

  assign head          = mem_q[rd_ptr_q[PtrW-1:0]];
  assign out_valid_o   = ~fifo_empty;
  assign out_data_o    = out_valid_o ? head[RowW-1:0] : '0;
  assign out_last_o    = out_valid_o & head[RowW];
  assign busy_o        = (state_q != IDLE) || (|valid_q) || !fifo_empty;
  assign overflow_o    = overflow_q;
  assign row_cnt_err_o = cnt_err_q;

endmodule

// File: tb/tb_acc_requant_writer.sv
`timescale 1ns/1ps
module tb_acc_requant_writer;

  localparam int SIZE = 16;
  localparam int AW   = 32;
  localparam int OW   = 8;
  localparam int RW   = OW * SIZE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] data_in [0:SIZE-1];
  logic [AW-1:0] bias_i [0:SIZE-1];
  logic          calc_done_i = 1'b0;
  logic          tile_calc_over_i = 1'b0;
  logic [31:0]   quant_mult_i;
  logic [4:0]    quant_shift_i;
  logic [OW-1:0] out_zp_i, act_min_i, act_max_i;
  logic          out_valid_o, out_ready_i, out_last_o, busy_o, overflow_o, row_cnt_err_o;
  logic [RW-1:0] out_data_o;

  acc_requant_writer #(
    .SIZE      (SIZE),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .FIFO_DEPTH(32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .calc_done_i     (calc_done_i),
    .tile_calc_over_i(tile_calc_over_i),
    .bias_i          (bias_i),
    .quant_mult_i    (quant_mult_i),
    .quant_shift_i   (quant_shift_i),
    .out_zp_i        (out_zp_i),
    .act_min_i       (act_min_i),
    .act_max_i       (act_max_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_data_o      (out_data_o),
    .out_last_o      (out_last_o),
    .busy_o          (busy_o),
    .overflow_o      (overflow_o),
    .row_cnt_err_o   (row_cnt_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
  } exp_row_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] bias;
    logic [31:0] mult;
    logic [4:0]  sh;
    logic [7:0]  zp;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  exp;
  } vec_t;

  exp_row_t exp_q[$];
  int       n_checks = 0;
  int       n_pass = 0;
  bit       chk_en = 1'b0;
  int       rdy_mode = 0;   // 0: hold low, 1: always high, 2: random

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: requantize one element straight from the arithmetic definition.
  function automatic logic [7:0] ref_elem(input logic [31:0] d, input logic [31:0] b);
    int     bsum;
    longint p, r, y;
    bsum = int'(d + b);
    p = longint'(bsum) * longint'($signed(quant_mult_i));
    r = (p + (longint'(1) <<< (30 + quant_shift_i))) >>> (31 + quant_shift_i);
    y = r + longint'($signed(out_zp_i));
    if (y < longint'($signed(act_min_i))) y = longint'($signed(act_min_i));
    if (y > longint'($signed(act_max_i))) y = longint'($signed(act_max_i));
    return y[7:0];
  endfunction

  function automatic logic [RW-1:0] ref_row();
    logic [RW-1:0] row;
    for (int c = 0; c < SIZE; c++) row[c*OW +: OW] = ref_elem(data_in[c], bias_i[c]);
    return row;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input logic [31:0] m, input logic [4:0] s, input logic [7:0] zp,
                            input logic [7:0] mn, input logic [7:0] mx);
    quant_mult_i = m; quant_shift_i = s; out_zp_i = zp; act_min_i = mn; act_max_i = mx;
  endtask

  task automatic send_row(input logic [RW-1:0] exp_data, input logic last);
    exp_q.push_back('{data: exp_data, last: last});
    calc_done_i = 1'b1;
    tick();
    calc_done_i = 1'b0;
  endtask

  task automatic pulse_over();
    tile_calc_over_i = 1'b1;
    tick();
    tile_calc_over_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; calc_done_i = 1'b0; tile_calc_over_i = 1'b0; rdy_mode = 0;
    tick(); tick();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic random_row();
    for (int c = 0; c < SIZE; c++) begin
      data_in[c] = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) data_in[c] = -data_in[c];
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid_o) && n < 3000) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Ready driver; runs 2ns after the edge so mode changes made at +1ns land this cycle.
  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready_i = 1'b0;
        1:       out_ready_i = 1'b1;
        default: out_ready_i = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Scoreboard: every accepted head must match the oldest expected row.
  always @(negedge clk) begin
    exp_row_t e;
    if (rst_n && chk_en && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", {{(RW-1){1'b0}}, out_valid_o}, '0);
      end else begin
        e = exp_q.pop_front();
        check("row_data", out_data_o, e.data);
        check("row_last", {{(RW-1){1'b0}}, out_last_o}, {{(RW-1){1'b0}}, e.last});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    logic [RW-1:0] hold;

    for (int c = 0; c < SIZE; c++) begin
      data_in[c] = '0;
      bias_i[c]  = '0;
    end
    set_params(32'h4000_0000, 5'd0, 8'd0, 8'h80, 8'h7f);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_last", out_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_cnt_err", row_cnt_err_o, 0);
    rst_n = 1'b1;
    tick();

    // Directed single-row vectors: {data, bias, mult, shift, zp, min, max, expected}
    vecs[0]  = '{32'd10,        32'd0,         32'h4000_0000, 5'd0,  8'd0,  8'h80, 8'h7f, 8'd5};
    vecs[1]  = '{32'hffff_fff9, 32'd0,         32'h4000_0000, 5'd1,  8'd3,  8'h80, 8'h7f, 8'd1};
    vecs[2]  = '{32'h7fff_ffff, 32'd1,         32'h4000_0000, 5'd0,  8'd0,  8'h80, 8'h7f, 8'h80};
    vecs[3]  = '{32'd100,       32'd0,         32'h4000_0000, 5'd0,  8'd0,  8'h80, 8'h00, 8'h00};
    vecs[4]  = '{32'hffff_fda8, 32'd0,         32'h4000_0000, 5'd0,  8'd0,  8'h80, 8'h00, 8'h80};
    vecs[5]  = '{32'd100,       32'd0,         32'h7fff_ffff, 5'd0,  8'hfb, 8'h80, 8'h7f, 8'd95};
    vecs[6]  = '{32'h7fff_ffff, 32'd0,         32'h7fff_ffff, 5'd31, 8'd0,  8'h80, 8'h7f, 8'd1};
    vecs[7]  = '{32'd3,         32'd0,         32'hc000_0000, 5'd0,  8'd0,  8'h80, 8'h7f, 8'hff};
    vecs[8]  = '{32'd5,         32'd0,         32'h4000_0000, 5'd0,  8'd0,  8'h80, 8'h7f, 8'd3};
    vecs[9]  = '{32'hffff_fffb, 32'd0,         32'h4000_0000, 5'd0,  8'd0,  8'h80, 8'h7f, 8'hfe};
    vecs[10] = '{32'd20,        32'hffff_fffc, 32'h4000_0000, 5'd0,  8'd0,  8'h80, 8'h7f, 8'd8};

    chk_en = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 11; i++) begin
      set_params(vecs[i].mult, vecs[i].sh, vecs[i].zp, vecs[i].mn, vecs[i].mx);
      for (int c = 0; c < SIZE; c++) begin
        data_in[c] = vecs[i].data;
        bias_i[c]  = vecs[i].bias;
      end
      send_row({SIZE{vecs[i].exp}}, 1'b0);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_lat_early", i), out_valid_o, 0);
      @(negedge clk);
      check($sformatf("vec%0d_lat_head", i), out_valid_o, 1);
      tick();
      rdy_mode = 1;
      tick();
      rdy_mode = 0;
    end
    tick();
    check("vec_all_popped", exp_q.size(), 0);

    // One full tile of constant data; last tag on row 15 only.
    do_reset();
    set_params(32'h4000_0000, 5'd0, 8'd0, 8'h80, 8'h7f);
    for (int c = 0; c < SIZE; c++) begin
      data_in[c] = 32'd10;
      bias_i[c]  = '0;
    end
    rdy_mode = 1;
    for (int r = 0; r < SIZE; r++) send_row({SIZE{8'd5}}, r == SIZE - 1);
    pulse_over();
    drain("tile");
    check("tile_busy_idle", busy_o, 0);
    check("tile_no_err", row_cnt_err_o, 0);
    check("tile_no_overflow", overflow_o, 0);

    // Overflow: 32 rows fill the FIFO with ready held low, the 33rd is dropped.
    do_reset();
    rdy_mode = 0;
    for (int r = 0; r < 32; r++) begin
      random_row();
      send_row(ref_row(), (r % SIZE) == SIZE - 1);
    end
    repeat (4) tick();
    check("ovf_not_yet", overflow_o, 0);
    check("ovf_head_valid", out_valid_o, 1);
    hold = exp_q[0].data;
    check("ovf_hold_data0", out_data_o, hold);
    random_row();
    calc_done_i = 1'b1;
    tick();
    calc_done_i = 1'b0;
    repeat (5) tick();
    check("ovf_set", overflow_o, 1);
    check("ovf_hold_data1", out_data_o, hold);
    check("ovf_model_depth", exp_q.size(), 32);
    rdy_mode = 1;
    drain("ovf");
    check("ovf_fifo_empty", out_valid_o, 0);
    check("ovf_sticky", overflow_o, 1);

    // Short tile: error flag, then a clean tile still tags row 15 as last.
    do_reset();
    rdy_mode = 1;
    for (int r = 0; r < 10; r++) begin
      random_row();
      send_row(ref_row(), 1'b0);
    end
    tick();
    check("err_before", row_cnt_err_o, 0);
    pulse_over();
    tick();
    check("err_set", row_cnt_err_o, 1);
    for (int r = 0; r < SIZE; r++) begin
      random_row();
      send_row(ref_row(), r == SIZE - 1);
    end
    pulse_over();
    drain("err");
    check("err_busy_idle", busy_o, 0);
    check("err_sticky", row_cnt_err_o, 1);

    // Random parameters and data, 4 tiles per round, random ready with throttling.
    for (int round = 0; round < 2; round++) begin
      logic [7:0] a, b;
      do_reset();
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($signed(a) > $signed(b)) begin
        logic [7:0] t;
        t = a; a = b; b = t;
      end
      set_params($urandom, 5'($urandom_range(0, 20)), 8'($urandom_range(0, 255)), a, b);
      for (int c = 0; c < SIZE; c++) bias_i[c] = $urandom >> $urandom_range(8, 31);
      rdy_mode = 2;
      for (int t = 0; t < 4; t++) begin
        for (int r = 0; r < SIZE; r++) begin
          int w = 0;
          while (exp_q.size() >= 24 && w < 500) begin
            tick();
            w++;
          end
          if (w == 500) check("throttle_timeout", exp_q.size(), 0);
          repeat ($urandom_range(0, 2)) tick();
          random_row();
          send_row(ref_row(), r == SIZE - 1);
        end
        pulse_over();
      end
      drain($sformatf("rand%0d", round));
      check($sformatf("rand%0d_busy", round), busy_o, 0);
      check($sformatf("rand%0d_overflow", round), overflow_o, 0);
      check($sformatf("rand%0d_cnt_err", round), row_cnt_err_o, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
